// File: rtl/uart_parity_engine_if.sv
// Generate-path handshake bundle for the UART parity engine.
// Master drives TX words in and drains results; slave is the engine.
interface uart_parity_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  gen_in_valid;
    logic                  gen_in_ready;
    logic [DATA_WIDTH-1:0] gen_in_data;
    logic                  gen_out_valid;
    logic                  gen_out_ready;
    logic [DATA_WIDTH-1:0] gen_out_data;
    logic                  gen_out_parity;

    modport master (
        output gen_in_valid,
        output gen_in_data,
        output gen_out_ready,
        input  gen_in_ready,
        input  gen_out_valid,
        input  gen_out_data,
        input  gen_out_parity
    );

    modport slave (
        input  gen_in_valid,
        input  gen_in_data,
        input  gen_out_ready,
        output gen_in_ready,
        output gen_out_valid,
        output gen_out_data,
        output gen_out_parity
    );
endinterface

// File: rtl/uart_parity_engine.sv
// Registered parity generate/check unit for the UART datapath.
// Runtime character length, four parity modes, sticky error stats.
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            parity_type,
    input  logic [LEN_W-1:0]      data_len,
    uart_parity_engine_if.slave   gen,
    input  logic                  chk_valid,
    input  logic [DATA_WIDTH-1:0] chk_data,
    input  logic                  chk_parity,
    output logic                  chk_err,
    output logic                  err_flag,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_MARK = 2'b11
    } par_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);

    function automatic logic calc_par(
        input par_t                  t,
        input logic [DATA_WIDTH-1:0] m
    );
        logic p;
        unique case (t)
            PAR_NONE: p = 1'b0;
            PAR_ODD:  p = ~^m;
            PAR_EVEN: p = ^m;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    par_t                  ptype;
    logic [LEN_W-1:0]      eff_len;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] gen_masked;
    logic [DATA_WIDTH-1:0] chk_masked;
    logic                  gen_par;
    logic                  chk_par;
    logic                  accept;

    logic                  gen_valid_q, gen_valid_d;
    logic [DATA_WIDTH-1:0] gen_data_q,  gen_data_d;
    logic                  gen_par_q,   gen_par_d;
    logic                  chk_err_q,   chk_err_d;
    logic                  err_flag_q,  err_flag_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q,   err_cnt_d;

    // Length mask and parity for both paths, from this cycle's config.
    always_comb begin
        ptype = par_t'(parity_type);
        eff_len = data_len;
        if (data_len == '0 || data_len > FULL_LEN) begin
            eff_len = FULL_LEN;
        end
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (LEN_W'(i) < eff_len);
        end
        gen_masked = gen.gen_in_data & mask;
        chk_masked = chk_data & mask;
        gen_par    = calc_par(ptype, gen_masked);
        chk_par    = calc_par(ptype, chk_masked);
    end

    assign gen.gen_in_ready = !gen_valid_q || gen.gen_out_ready;
    assign accept = gen.gen_in_valid && gen.gen_in_ready;

    // Output register: load on accept, drop valid on a drain-only cycle.
    always_comb begin
        gen_valid_d = gen_valid_q;
        gen_data_d  = gen_data_q;
        gen_par_d   = gen_par_q;
        if (accept) begin
            gen_valid_d = 1'b1;
            gen_data_d  = gen_masked;
            gen_par_d   = gen_par;
        end else if (gen.gen_out_ready) begin
            gen_valid_d = 1'b0;
        end
    end

    // Mismatch detect plus sticky flag / saturating counter; error beats clear.
    always_comb begin
        chk_err_d  = chk_valid && (ptype != PAR_NONE)
                     && (chk_parity != chk_par);
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (chk_err_q) begin
            err_flag_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // State registers; reset drops any pending output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_valid_q <= 1'b0;
            gen_data_q  <= '0;
            gen_par_q   <= 1'b0;
            chk_err_q   <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            gen_valid_q <= gen_valid_d;
            gen_data_q  <= gen_data_d;
            gen_par_q   <= gen_par_d;
            chk_err_q   <= chk_err_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gen.gen_out_valid  = gen_valid_q;
    assign gen.gen_out_data   = gen_data_q;
    assign gen.gen_out_parity = gen_par_q;
    assign chk_err   = chk_err_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_cnt_q;

endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
- Parametrised, registered parity unit for the UART datapath; successor to the fixed 8-bit combinational parity block.
- Generate path: computes the parity bit for TX words through a one-stage valid/ready pipeline.
- Check path: verifies RX words plus their received parity bit, and keeps a sticky error flag and a saturating error counter.
- Supports a runtime character length (low bits only) and four parity modes.

Parameters:
- DATA_WIDTH, 8, maximum character width in bits.
- LEN_W, 4, width of the data_len port; must satisfy 2**LEN_W > DATA_WIDTH.
- ERR_CNT_W, 8, width of the parity error counter.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 mark (parity bit always 1).
- data_len  input  LEN_W  number of valid low data bits, 1..DATA_WIDTH.
- gen_in_valid  input  1  TX word valid.
- gen_in_ready  output  1  generate stage can accept.
- gen_in_data  input  DATA_WIDTH  TX word.
- gen_out_valid  output  1  registered result valid.
- gen_out_ready  input  1  downstream accepts result.
- gen_out_data  output  DATA_WIDTH  TX word, with bits at or above data_len forced to 0.
- gen_out_parity  output  1  generated parity bit.
- chk_valid  input  1  RX word plus parity bit present (single-cycle strobe, no backpressure).
- chk_data  input  DATA_WIDTH  RX word.
- chk_parity  input  1  received parity bit.
- chk_err  output  1  one-cycle pulse: parity mismatch on the word presented the previous cycle.
- err_flag  output  1  sticky error flag.
- err_clr  input  1  synchronous clear of err_flag and err_count.
- err_count  output  ERR_CNT_W  saturating count of mismatches.

Behaviour:
- Reset (rst=0, asynchronous): gen_out_valid=0, gen_out_data=0, gen_out_parity=0, chk_err=0, err_flag=0, err_count=0.
- Length mask:
  - The effective length L = data_len.
  - When data_len is 0 or greater than DATA_WIDTH, L = DATA_WIDTH.
  - Only bits [L-1:0] enter the parity computation; upper bits are ignored.
- Parity function P(x) over the masked bits:
  - none: 0.
  - odd: ~^ of the masked bits, i.e. 1 when the count of ones is even.
  - even: ^ of the masked bits.
  - mark: 1.
- parity_type and data_len are sampled per beat, on the cycle the beat is accepted; a mid-stream change affects only later beats.
- Generate path (one register stage, latency 1):
  - gen_in_ready = !gen_out_valid || gen_out_ready, purely combinational from state and gen_out_ready.
  - On gen_in_valid && gen_in_ready, the output register loads the masked data and P(data), and gen_out_valid=1 next cycle.
  - On gen_out_ready && gen_out_valid with no new accept, gen_out_valid=0.
  - Simultaneous output drain and input accept sustain full throughput: one word per cycle with gen_out_valid held at 1.
  - While gen_out_valid && !gen_out_ready, the output data and parity hold stable.
- Check path (latency 1):
  - On chk_valid, mismatch = (parity_type != none) && (chk_parity != P(chk_data)).
  - chk_err is registered and equals that mismatch on the next cycle; otherwise chk_err=0.
  - Mode none never flags an error.
- err_flag: set by any chk_err event; cleared only by err_clr or reset.
- err_count: increments by 1 per chk_err event and saturates at all-ones (no wrap).
- err_clr coinciding with a new chk_err event: the error wins, giving err_flag=1 and err_count=1.
- Reset asserted mid-transfer drops any pending gen_out word; nothing is replayed after reset.

Test Plan:
- Reset, then gen_in 8'hA5 (four ones) with data_len=8 -> one cycle later gen_out_valid=1, gen_out_data=8'hA5; gen_out_parity=0 in even, 1 in odd, 1 in mark, 0 in none.
- data_len=5 with gen_in_data 8'hF1 in even mode -> gen_out_data=8'h11, gen_out_parity=0 (bits [4:0]=10001 hold two ones).
- Backpressure: gen_out_ready=0 for 3 cycles after loading 8'h01 -> gen_in_ready=0, output holds 8'h01 with parity 1 (even); a back-to-back stream with gen_out_ready=1 -> one word per cycle, none lost or duplicated.
- Check, odd mode: chk_data 8'h03 with chk_parity=0 -> chk_err pulses once, err_flag=1, err_count=1; the same word with chk_parity=1 -> no error.
- ERR_CNT_W=2 with 5 consecutive errors -> err_count stops at 3; err_clr together with an error -> err_flag=1, err_count=1; err_clr alone -> both 0.
- Random data, lengths and modes against a reference model, with rst pulled low mid-stream -> all outputs 0 immediately, and correct results resume after release.
